// File: rtl/lcd_bus_sched_if.sv
// lcd_bus_sched_if: requester handshakes plus LCD pin bundle for the bus scheduler
interface lcd_bus_sched_if;
  logic       req0_valid, req0_rs, req0_nib, req0_ready;
  logic [7:0] req0_data;
  logic       req1_valid, req1_rs, req1_nib, req1_ready;
  logic [7:0] req1_data;
  logic       grant, busy, RS, E, D4, D5, D6, D7;
  modport master (
    output req0_valid, req0_rs, req0_nib, req0_data,
    output req1_valid, req1_rs, req1_nib, req1_data,
    input  req0_ready, req1_ready, grant, busy, RS, E, D4, D5, D6, D7
  );
  modport slave (
    input  req0_valid, req0_rs, req0_nib, req0_data,
    input  req1_valid, req1_rs, req1_nib, req1_data,
    output req0_ready, req1_ready, grant, busy, RS, E, D4, D5, D6, D7
  );
endinterface

// File: rtl/lcd_bus_sched.sv
// lcd_bus_sched: round-robin two-requester scheduler driving a 4-bit HD44780 bus
module lcd_bus_sched #(
  parameter int E_HIGH    = 2,
  parameter int E_LOW     = 2,
  parameter int CMD_WAIT  = 40,
  parameter int LONG_WAIT = 1600
) (
  input logic CLK,
  input logic RST,
  lcd_bus_sched_if.slave bus
);
  localparam int CW = $clog2(LONG_WAIT + 1);
  localparam logic [CW-1:0] EH1 = CW'(E_HIGH - 1);
  localparam logic [CW-1:0] EL1 = CW'(E_LOW - 1);
  localparam logic [CW-1:0] CW1 = CW'(CMD_WAIT - 1);
  localparam logic [CW-1:0] LW1 = CW'(LONG_WAIT - 1);
  typedef enum logic [2:0] {IDLE, SETUP_H, PULSE_H, HOLD_H, SETUP_L, PULSE_L, HOLD_L, WAIT} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n, wait1;
  logic [7:0] data_q, sel_data;
  logic [3:0] d_o;
  logic rs_q, nib_q, last_grant, grant_q, rs_o;
  logic chosen, go, done, long_w, sel_rs, sel_nib;
  assign chosen   = (bus.req0_valid & bus.req1_valid) ? ~last_grant : bus.req1_valid;
  assign go       = (state == IDLE) & !RST & (bus.req0_valid | bus.req1_valid);
  assign sel_rs   = chosen ? bus.req1_rs : bus.req0_rs;
  assign sel_nib  = chosen ? bus.req1_nib : bus.req0_nib;
  assign sel_data = chosen ? bus.req1_data : bus.req0_data;
  // clear (0x01), home (0x02/0x03) and 8-bit init nibbles need the long settle
  assign long_w   = nib_q | (!rs_q & data_q[7:2] == 6'd0 & data_q[1:0] != 2'd0);
  assign wait1    = long_w ? LW1 : CW1;
  assign done     = cnt == '0;
  assign bus.req0_ready = go & !chosen;
  assign bus.req1_ready = go & chosen;
  assign bus.grant = grant_q;
  assign bus.busy  = state != IDLE;
  assign bus.E     = (state == PULSE_H) | (state == PULSE_L);
  assign bus.RS    = rs_o;
  assign {bus.D7, bus.D6, bus.D5, bus.D4} = d_o;
  // next state: each state loads the shared down-counter with its length minus one
  always_comb begin
    state_n = state;
    cnt_n   = done ? '0 : cnt - CW'(1);
    case (state)
      IDLE:    if (go) state_n = SETUP_H;
      SETUP_H: begin state_n = PULSE_H; cnt_n = EH1; end
      PULSE_H: if (done) begin state_n = HOLD_H; cnt_n = EL1; end
      HOLD_H:  if (done) begin state_n = nib_q ? WAIT : SETUP_L; cnt_n = nib_q ? wait1 : '0; end
      SETUP_L: begin state_n = PULSE_L; cnt_n = EH1; end
      PULSE_L: if (done) begin state_n = HOLD_L; cnt_n = EL1; end
      HOLD_L:  if (done) begin state_n = WAIT; cnt_n = wait1; end
      WAIT:    if (done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // state, latched request and pin registers; RS/D only change on entry to a setup state
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= '0;
      rs_q       <= 1'b0;
      nib_q      <= 1'b0;
      data_q     <= '0;
      last_grant <= 1'b1;
      grant_q    <= 1'b0;
      rs_o       <= 1'b0;
      d_o        <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (go) begin
        rs_q       <= sel_rs;
        nib_q      <= sel_nib;
        data_q     <= sel_data;
        grant_q    <= chosen;
        last_grant <= chosen;
        rs_o       <= sel_rs;
        d_o        <= sel_data[7:4];
      end
      if (state == HOLD_H && state_n == SETUP_L) d_o <= data_q[3:0];
    end
  end
endmodule
